// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: one state per cycle, shared memory/ALU, memory waits via mem_ready.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal) instead of retiring as a NOP.
module mips_multicycle_ctrl (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic [1:0] o_pc_source,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_reg_write,
    output logic [1:0] o_reg_dst,
    output logic [1:0] o_mem_to_reg,
    output logic       o_retire,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB    = 4'd11,
        S_JAL    = 4'd12, S_JR     = 4'd13, S_TRAP   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    state_t r_state;
    state_t w_decode_next;

    always_comb begin
        w_decode_next = S_FETCH;
        case (i_opcode)
            OP_RTYPE:       w_decode_next = (i_funct == FN_JR) ? S_JR : S_EXEC;
            OP_ADDI,
            OP_ANDI:        w_decode_next = S_IEXEC;
            OP_LW,
            OP_SW:          w_decode_next = S_MEMADR;
            OP_BEQ:         w_decode_next = S_BRANCH;
            OP_J:           w_decode_next = S_JUMP;
            OP_JAL:         w_decode_next = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
            default:        w_decode_next = S_TRAP;
`else
            default:        w_decode_next = S_FETCH;
`endif
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (i_mem_ready) r_state <= S_DECODE;
                S_DECODE: r_state <= w_decode_next;
                S_MEMADR: r_state <= (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (i_mem_ready) r_state <= S_MEMWB;
                S_MEMWR:  if (i_mem_ready) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_IEXEC:  r_state <= S_IWB;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Reset gates every output so an aborted instruction cannot write during the reset cycle.
    always_comb begin
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_iord          = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_pc_source     = 2'd0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'd0;
        o_alu_op        = 2'b00;
        o_reg_write     = 1'b0;
        o_reg_dst       = 2'd0;
        o_mem_to_reg    = 2'd0;
        o_retire        = 1'b0;
        o_state         = 4'd0;
        o_illegal       = 1'b0;
        if (!i_reset) begin
            o_state = r_state;
            case (r_state)
                S_FETCH: begin
                    o_mem_req   = 1'b1;
                    o_alu_src_b = 2'd1;
                    o_ir_write  = i_mem_ready;
                    o_pc_write  = i_mem_ready;
                end
                S_DECODE: begin
                    o_alu_src_b = 2'd3;
`ifndef MC_ILLEGAL_TRAP_EN
                    o_retire    = (w_decode_next == S_FETCH);
`endif
                end
                S_MEMADR: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'd2;
                end
                S_MEMRD: begin
                    o_mem_req = 1'b1;
                    o_iord    = 1'b1;
                end
                S_MEMWB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 2'd1;
                    o_retire     = 1'b1;
                end
                S_MEMWR: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = 1'b1;
                    o_iord    = 1'b1;
                    o_retire  = i_mem_ready;
                end
                S_EXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_op    = 2'b10;
                end
                S_RWB: begin
                    o_reg_write = 1'b1;
                    o_reg_dst   = 2'd1;
                    o_retire    = 1'b1;
                end
                S_BRANCH: begin
                    o_alu_src_a     = 1'b1;
                    o_alu_op        = 2'b01;
                    o_pc_write_cond = 1'b1;
                    o_pc_source     = 2'd1;
                    o_retire        = 1'b1;
                end
                S_JUMP: begin
                    o_pc_write  = 1'b1;
                    o_pc_source = 2'd2;
                    o_retire    = 1'b1;
                end
                S_IEXEC: begin
                    o_alu_src_a = 1'b1;
                    o_alu_src_b = 2'd2;
                    o_alu_op    = (i_opcode == OP_ANDI) ? 2'b11 : 2'b00;
                end
                S_IWB: begin
                    o_reg_write = 1'b1;
                    o_retire    = 1'b1;
                end
                S_JAL: begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = 2'd2;
                    o_mem_to_reg = 2'd2;
                    o_pc_write   = 1'b1;
                    o_pc_source  = 2'd2;
                    o_retire     = 1'b1;
                end
                S_JR: begin
                    o_pc_write  = 1'b1;
                    o_pc_source = 2'd3;
                    o_retire    = 1'b1;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:   o_illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboarded bench for mips_multicycle_ctrl: per-cycle expected outputs and per-instruction latency.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       retire;
        logic [3:0] state;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic       alu_src_a, reg_write, retire, illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;
    outs_t exp_q[$];
    int    lat_q[$];
    int    cyc = 0;
    logic [5:0] cur_op = 6'h00;
    logic [5:0] cur_fn = 6'h00;

    mips_multicycle_ctrl dut (
        .i_clock(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct),
        .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_iord(iord),
        .o_ir_write(ir_write), .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond),
        .o_pc_source(pc_source), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_alu_op(alu_op), .o_reg_write(reg_write), .o_reg_dst(reg_dst),
        .o_mem_to_reg(mem_to_reg), .o_retire(retire), .o_state(state), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_known(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C, 6'h23, 6'h2B};
    endfunction

    // Expected outputs straight from the per-state output table.
    function automatic outs_t exp_vec(input logic rst, input logic rdy, input logic [3:0] st,
                                      input logic [5:0] op);
        outs_t e;
        e = '0;
        if (rst) return e;
        e.state = st;
        case (st)
            4'd0:  begin e.mem_req = 1; e.alu_src_b = 1; e.ir_write = rdy; e.pc_write = rdy; end
            4'd1:  begin
                e.alu_src_b = 3;
`ifndef MC_ILLEGAL_TRAP_EN
                e.retire = !is_known(op);
`endif
            end
            4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2; end
            4'd3:  begin e.mem_req = 1; e.iord = 1; end
            4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
            4'd5:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.retire = rdy; end
            4'd6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            4'd7:  begin e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
            4'd8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                         e.pc_source = 1; e.retire = 1; end
            4'd9:  begin e.pc_write = 1; e.pc_source = 2; e.retire = 1; end
            4'd10: begin e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = (op == 6'h0C) ? 2'b11 : 2'b00; end
            4'd11: begin e.reg_write = 1; e.retire = 1; end
            4'd12: begin e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 2; e.pc_write = 1;
                         e.pc_source = 2; e.retire = 1; end
            4'd13: begin e.pc_write = 1; e.pc_source = 3; e.retire = 1; end
            4'd14: e.illegal = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [3:0] st);
        @(posedge clk);
        #1;
        reset = rst;
        mem_ready = rdy;
        opcode = cur_op;
        funct = cur_fn;
        exp_q.push_back(exp_vec(rst, rdy, st, cur_op));
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        logic [3:0] seq[$];
        int base;
        logic rdy;
        cur_op = op;
        cur_fn = fn;
        base = 0;
        case (op)
            6'h00:   if (fn == 6'h08) begin seq = '{4'd0, 4'd1, 4'd13}; base = 3; end
                     else begin seq = '{4'd0, 4'd1, 4'd6, 4'd7}; base = 4; end
            6'h08,
            6'h0C:   begin seq = '{4'd0, 4'd1, 4'd10, 4'd11}; base = 4; end
            6'h23:   begin seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; base = 5; end
            6'h2B:   begin seq = '{4'd0, 4'd1, 4'd2, 4'd5}; base = 4; end
            6'h04:   begin seq = '{4'd0, 4'd1, 4'd8}; base = 3; end
            6'h02:   begin seq = '{4'd0, 4'd1, 4'd9}; base = 3; end
            6'h03:   begin seq = '{4'd0, 4'd1, 4'd12}; base = 3; end
`ifdef MC_ILLEGAL_TRAP_EN
            default: seq = '{4'd0, 4'd1, 4'd14, 4'd14, 4'd14, 4'd14};
`else
            default: begin seq = '{4'd0, 4'd1}; base = 2; end
`endif
        endcase
        if (base != 0) lat_q.push_back(base + fw + mw);
        foreach (seq[i]) begin
            if (seq[i] == 4'd0) repeat (fw) step(1'b0, 1'b0, 4'd0);
            if (seq[i] == 4'd3 || seq[i] == 4'd5) repeat (mw) step(1'b0, 1'b0, seq[i]);
            rdy = (seq[i] == 4'd0 || seq[i] == 4'd3 || seq[i] == 4'd5) ? 1'b1
                                                                       : 1'($urandom_range(0, 1));
            step(1'b0, rdy, seq[i]);
        end
`ifdef MC_ILLEGAL_TRAP_EN
        if (base == 0) step(1'b1, 1'b1, 4'd0);
`endif
    endtask

    always @(negedge clk) begin
        outs_t obs;
        outs_t e;
        obs = '{mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, retire, state, illegal};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("outs st%0d", e.state), 32'(obs), 32'(e));
        end
        if (reset) begin
            cyc = 0;
        end else begin
            cyc++;
            if (retire) begin
                if (lat_q.size() > 0) check("latency", 32'(cyc), 32'(lat_q.pop_front()));
                else check("retire_unexpected", 32'(1), 32'(0));
                cyc = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b1, 1'b1, 4'd0);
        step(1'b1, 1'b1, 4'd0);
        instr(6'h00, 6'h20, 0, 0);   // add
        instr(6'h23, 6'h00, 0, 2);   // lw, two MEMRD waits
        instr(6'h23, 6'h11, 1, 0);   // lw, one fetch wait
        instr(6'h2B, 6'h00, 0, 1);   // sw, one MEMWR wait
        instr(6'h2B, 6'h00, 0, 0);
        instr(6'h00, 6'h24, 2, 0);   // and
        instr(6'h00, 6'h27, 0, 0);   // nor
        instr(6'h00, 6'h2A, 0, 0);   // slt
        instr(6'h00, 6'h00, 0, 0);   // sll
        instr(6'h08, 6'h3F, 0, 0);   // addi
        instr(6'h0C, 6'h08, 0, 0);   // andi
        instr(6'h04, 6'h00, 1, 0);   // beq
        instr(6'h02, 6'h00, 0, 0);   // j
        instr(6'h03, 6'h00, 0, 0);   // jal
        instr(6'h00, 6'h08, 0, 0);   // jr
        instr(6'h3F, 6'h00, 0, 0);   // unknown opcode
        instr(6'h00, 6'h20, 0, 0);
        // sw aborted by reset while MEMWR is waiting
        cur_op = 6'h2B;
        cur_fn = 6'h00;
        step(1'b0, 1'b1, 4'd0);
        step(1'b0, 1'b0, 4'd1);
        step(1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b0, 4'd5);
        step(1'b0, 1'b0, 4'd5);
        step(1'b1, 1'b0, 4'd5);
        instr(6'h00, 6'h20, 0, 0);
        @(negedge clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("lat_q_drained", 32'(lat_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
